fc_data_feeder: RTL

FC_DATA_FEEDER -- requirements
Module: fc_data_feeder

---
 rtl/fc_data_feeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fc_data_feeder.sv
// Sequences shared node/weight SRAM reads into a downstream FC core and
// captures the core's accumulator once every element result has come back.
module fc_data_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_start,
   input  logic [ADDR_WIDTH:0]     i_num_cnt,
   output logic                    o_idle,
   output logic                    o_done,
   output logic [4*DATA_WIDTH-1:0] o_result,
   output logic                    o_mem_ce,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   input  logic [DATA_WIDTH-1:0]   i_node_q,
   input  logic [DATA_WIDTH-1:0]   i_wegt_q,
   output logic                    o_core_run,
   output logic                    o_core_valid,
   output logic [DATA_WIDTH-1:0]   o_core_node,
   output logic [DATA_WIDTH-1:0]   o_core_wegt,
   input  logic                    i_core_valid,
   input  logic [4*DATA_WIDTH-1:0] i_core_result
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int RW = 4 * DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_READ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   num_q;
   logic [CW-1:0]   rd_cnt;
   logic [CW-1:0]   res_cnt;
   logic            core_valid_q;
   logic [RW-1:0]   result_q;
   logic            accept_start;
   logic            counting;
   logic            rd_last;
   logic            res_hit;

   assign accept_start = (state == S_IDLE) && i_start;
   assign counting     = (state == S_READ) || (state == S_WAIT);
   assign rd_last      = (rd_cnt == (num_q - CW'(1)));
   // The result is final on the core-valid pulse that completes the N-th element.
   assign res_hit      = counting && i_core_valid && ((res_cnt + CW'(1)) == num_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (i_start) begin
               state_next = (i_num_cnt == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: state_next = S_READ;
         S_READ: begin
            if (res_hit) begin
               state_next = S_DONE;
            end else if (rd_last) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (res_hit) begin
               state_next = S_DONE;
            end
         end
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_q        <= '0;
         rd_cnt       <= '0;
         res_cnt      <= '0;
         core_valid_q <= 1'b0;
         result_q     <= '0;
      end else begin
         core_valid_q <= (state == S_READ);
         if (accept_start) begin
            num_q <= i_num_cnt;
         end
         if (state == S_CLEAR) begin
            rd_cnt  <= '0;
            res_cnt <= '0;
         end else begin
            if (state == S_READ) begin
               rd_cnt <= rd_cnt + CW'(1);
            end
            if (counting && i_core_valid) begin
               res_cnt <= res_cnt + CW'(1);
            end
         end
         // A zero-length request still reports a defined (empty) dot product.
         if (accept_start && (i_num_cnt == '0)) begin
            result_q <= '0;
         end else if (res_hit) begin
            result_q <= i_core_result;
         end
      end
   end

   assign o_idle       = (state == S_IDLE);
   assign o_done       = (state == S_DONE);
   assign o_result     = result_q;
   assign o_mem_ce     = (state == S_READ);
   assign o_mem_addr   = (state == S_READ) ? rd_cnt[ADDR_WIDTH-1:0] : '0;
   assign o_core_run   = (state == S_CLEAR);
   assign o_core_valid = core_valid_q;
   assign o_core_node  = i_node_q;
   assign o_core_wegt  = i_wegt_q;

endmodule
